// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: per-frame sprite position update with edge bounce, started on vsync rise
module sprite_motion_ctrl #(
    parameter int NUM_SPRITES = 4,
    parameter int COORD_W     = 16,
    parameter int SCREEN_W    = 800,
    parameter int SCREEN_H    = 600,
    parameter int SPR_W       = 16,
    parameter int SPR_H       = 16,
    localparam int IDX_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                             i_pix_clk,
    input  logic                             i_reset,
    input  logic                             i_vert_sync,
    input  logic                             i_enable,
    input  logic                             i_load_valid,
    output logic                             o_load_ready,
    input  logic [IDX_W-1:0]                 i_load_idx,
    input  logic signed [COORD_W-1:0]        i_load_x,
    input  logic signed [COORD_W-1:0]        i_load_y,
    input  logic signed [COORD_W-1:0]        i_load_vx,
    input  logic signed [COORD_W-1:0]        i_load_vy,
    output logic [NUM_SPRITES*COORD_W-1:0]   o_x_coords,
    output logic [NUM_SPRITES*COORD_W-1:0]   o_y_coords,
    output logic [NUM_SPRITES-1:0]           o_bounce,
    output logic                             o_busy,
    output logic                             o_frame_done
);
    localparam int XMAX_I = SCREEN_W - SPR_W;
    localparam int YMAX_I = SCREEN_H - SPR_H;
    localparam logic signed [COORD_W:0] XMAX = XMAX_I[COORD_W:0];
    localparam logic signed [COORD_W:0] YMAX = YMAX_I[COORD_W:0];
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SPRITES - 1);

    typedef logic signed [COORD_W-1:0] coord_t;
    typedef enum logic {IDLE, UPDATE} state_t;

    state_t                   state;
    logic [IDX_W-1:0]         idx;
    logic                     vs_prev;
    logic                     rise;
    logic                     frame_done;
    logic [NUM_SPRITES-1:0]   bounce;
    coord_t                   px [NUM_SPRITES];
    coord_t                   py [NUM_SPRITES];
    coord_t                   vx [NUM_SPRITES];
    coord_t                   vy [NUM_SPRITES];
    logic [2*COORD_W:0]       sx;
    logic [2*COORD_W:0]       sy;

    // One axis step: returns {hit, new position, new velocity}; sum is one bit wider so it cannot wrap
    function automatic logic [2*COORD_W:0] step(input coord_t p, input coord_t v, input logic signed [COORD_W:0] lim);
        logic signed [COORD_W:0] n;
        n = $signed({p[COORD_W-1], p}) + $signed({v[COORD_W-1], v});
        if (n > lim) return {1'b1, lim[COORD_W-1:0], -v};
        if (n[COORD_W]) return {1'b1, {COORD_W{1'b0}}, -v};
        return {1'b0, n[COORD_W-1:0], v};
    endfunction

    function automatic coord_t clamp(input coord_t v, input logic signed [COORD_W:0] lim);
        return v[COORD_W-1] ? '0 : ($signed({1'b0, v}) > lim) ? lim[COORD_W-1:0] : v;
    endfunction

    assign rise         = i_vert_sync & ~vs_prev;
    assign sx           = step(px[idx], vx[idx], XMAX);
    assign sy           = step(py[idx], vy[idx], YMAX);
    assign o_load_ready = (state == IDLE) & ~i_reset;
    assign o_busy       = state == UPDATE;
    assign o_frame_done = frame_done;
    assign o_bounce     = bounce;

    for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_out
        assign o_x_coords[k*COORD_W +: COORD_W] = px[k];
        assign o_y_coords[k*COORD_W +: COORD_W] = py[k];
    end

    // vsync history for rising-edge detection
    always_ff @(posedge i_pix_clk) begin
        vs_prev <= i_reset ? 1'b0 : i_vert_sync;
    end

    // FSM: loads and pass start in IDLE, one sprite per cycle in UPDATE
    always_ff @(posedge i_pix_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            idx        <= '0;
            bounce     <= '0;
            frame_done <= 1'b0;
            for (int k = 0; k < NUM_SPRITES; k++) begin
                px[k] <= '0;
                py[k] <= '0;
                vx[k] <= '0;
                vy[k] <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            if (state == IDLE) begin
                if (i_load_valid && 32'(i_load_idx) < NUM_SPRITES) begin
                    px[i_load_idx] <= clamp(i_load_x, XMAX);
                    py[i_load_idx] <= clamp(i_load_y, YMAX);
                    vx[i_load_idx] <= i_load_vx;
                    vy[i_load_idx] <= i_load_vy;
                end
                if (rise && i_enable) begin
                    state  <= UPDATE;
                    idx    <= '0;
                    bounce <= '0;
                end
            end else begin
                px[idx]     <= sx[2*COORD_W-1:COORD_W];
                vx[idx]     <= sx[COORD_W-1:0];
                py[idx]     <= sy[2*COORD_W-1:COORD_W];
                vy[idx]     <= sy[COORD_W-1:0];
                bounce[idx] <= sx[2*COORD_W] | sy[2*COORD_W];
                if (idx == LAST) begin
                    state      <= IDLE;
                    frame_done <= 1'b1;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: directed scoreboard bench, frame results checked on o_frame_done
module tb_sprite_motion_ctrl;
    localparam int CW = 16;

    logic clk = 0, rst = 1, vs = 0, en = 1, lv = 0, b_lv = 0;
    logic [1:0] li = 0;
    logic [2:0] b_li = 0;
    logic signed [CW-1:0] lx = 0, ly = 0, lvx = 0, lvy = 0;
    logic ready, busy, fd, b_ready, b_busy, b_fd;
    logic [4*CW-1:0] xc, yc;
    logic [3:0] bnc;
    logic [5*CW-1:0] b_xc, b_yc;
    logic [4:0] b_bnc;

    typedef struct {int x0; int y0; int b;} exp_t;
    exp_t q[$];
    exp_t e;
    int checks = 0, fails = 0, busy_cnt = 0;
    logic prev_fd = 0;

    always #5 clk = ~clk;

    sprite_motion_ctrl u_dut (
        .i_pix_clk(clk), .i_reset(rst), .i_vert_sync(vs), .i_enable(en),
        .i_load_valid(lv), .o_load_ready(ready), .i_load_idx(li),
        .i_load_x(lx), .i_load_y(ly), .i_load_vx(lvx), .i_load_vy(lvy),
        .o_x_coords(xc), .o_y_coords(yc), .o_bounce(bnc), .o_busy(busy), .o_frame_done(fd)
    );

    sprite_motion_ctrl #(.NUM_SPRITES(5)) u_dut5 (
        .i_pix_clk(clk), .i_reset(rst), .i_vert_sync(1'b0), .i_enable(1'b0),
        .i_load_valid(b_lv), .o_load_ready(b_ready), .i_load_idx(b_li),
        .i_load_x(lx), .i_load_y(ly), .i_load_vx(lvx), .i_load_vy(lvy),
        .o_x_coords(b_xc), .o_y_coords(b_yc), .o_bounce(b_bnc), .o_busy(b_busy), .o_frame_done(b_fd)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int xs(input int k);
        return int'($signed(xc[k*CW +: CW]));
    endfunction

    function automatic int ys(input int k);
        return int'($signed(yc[k*CW +: CW]));
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input int x, input int y, input int vxv, input int vyv);
        int n = 0;
        li = 2'(idx); lx = 16'(x); ly = 16'(y); lvx = 16'(vxv); lvy = 16'(vyv); lv = 1;
        while (!ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) check("load_timeout", 0, 1);
        tick();
        lv = 0;
    endtask

    task automatic frame(input int x0, input int y0, input int b);
        q.push_back('{x0, y0, b});
        vs = 1;
        tick();
        vs = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check("drain_queue", q.size(), 0);
        tick(2);
    endtask

    // monitor: pops one expected frame per o_frame_done and checks pulse width and pass length
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
            prev_fd = 0;
        end else begin
            if (prev_fd) check("frame_done_width", int'(fd), 0);
            if (busy) busy_cnt++;
            if (fd) begin
                if (q.size() == 0) check("unexpected_frame_done", 1, 0);
                else begin
                    e = q.pop_front();
                    check("x0", xs(0), e.x0);
                    check("y0", ys(0), e.y0);
                    check("bounce", int'(bnc), e.b);
                    check("busy_cycles", busy_cnt, 4);
                end
                busy_cnt = 0;
            end
            prev_fd = fd;
        end
    end

    initial begin
        tick(3);
        check("reset_ready", int'(ready), 0);
        check("reset_x_zero", int'(xc == '0), 1);
        check("reset_y_zero", int'(yc == '0), 1);
        check("reset_bounce", int'(bnc), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_frame_done", int'(fd), 0);
        rst = 0;
        tick();
        check("ready_after_reset", int'(ready), 1);

        load(0, 10, 20, 5, 6);
        check("load_x0", xs(0), 10);
        frame(15, 26, 0);
        drain();

        load(0, 780, 582, 5, 6);
        frame(784, 584, 1);
        drain();
        frame(779, 578, 0);
        drain();

        load(0, 3, 2, -5, -6);
        frame(0, 0, 1);
        drain();
        frame(5, 6, 0);
        drain();

        q.push_back('{10, 12, 0});
        vs = 1;
        tick(10);
        vs = 0;
        drain();
        tick(10);

        q.push_back('{15, 18, 0});
        vs = 1;
        tick();
        vs = 0;
        tick();
        vs = 1;
        tick();
        vs = 0;
        drain();
        tick(8);
        check("busy_after_ignored_rise", int'(busy), 0);

        en = 0;
        vs = 1;
        tick();
        vs = 0;
        tick(8);
        check("disabled_x0", xs(0), 15);
        check("disabled_busy", int'(busy), 0);
        en = 1;

        frame(20, 24, 0);
        check("ready_in_pass", int'(ready), 0);
        load(1, 100, 50, 0, 0);
        check("late_load_x1", xs(1), 100);
        check("late_load_y1", ys(1), 50);
        drain();

        li = 0; lx = 400; ly = 300; lvx = -10; lvy = 10; lv = 1;
        q.push_back('{390, 310, 0});
        vs = 1;
        tick();
        lv = 0;
        vs = 0;
        drain();

        load(2, 900, -7, 0, 0);
        check("clamp_x2", xs(2), 784);
        check("clamp_y2", ys(2), 0);

        b_li = 2; lx = 7; ly = 8; b_lv = 1;
        tick();
        b_li = 5; lx = 300; ly = 300;
        tick();
        b_lv = 0;
        check("n5_ready", int'(b_ready), 1);
        check("n5_x_idx5_ignored", int'(b_xc == {16'd0, 16'd0, 16'd7, 16'd0, 16'd0}), 1);
        check("n5_y_idx5_ignored", int'(b_yc == {16'd0, 16'd0, 16'd8, 16'd0, 16'd0}), 1);

        vs = 1;
        tick();
        vs = 0;
        tick();
        rst = 1;
        tick();
        check("midreset_x_zero", int'(xc == '0), 1);
        check("midreset_y_zero", int'(yc == '0), 1);
        check("midreset_n5_x_zero", int'(b_xc == '0), 1);
        check("midreset_ready", int'(ready), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_frame_done", int'(fd), 0);
        rst = 0;
        tick();
        check("ready_after_midreset", int'(ready), 1);
        check("idle_after_midreset", int'(busy), 0);
        tick(10);
        check("queue_empty_end", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/sprite_motion_ctrl.md
SPRITE_MOTION_CTRL -- requirements
Module: sprite_motion_ctrl

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 4: number of independently moving sprites, range 1..16.
REQ-002 SHALL have parameter COORD_W, default 16: signed coordinate and velocity width.
REQ-003 SHALL have parameters SCREEN_W, default 800, and SCREEN_H, default 600: active area in pixels.
REQ-004 SHALL have parameters SPR_W, default 16, and SPR_H, default 16: sprite size, so XMAX = SCREEN_W-SPR_W and YMAX = SCREEN_H-SPR_H.
REQ-005 SHALL have derived localparam IDX_W = max(1, clog2(NUM_SPRITES)).
REQ-006 SHALL have port i_pix_clk, input, 1 bit: sole clock, rising edge.
REQ-007 SHALL have port i_reset, input, 1 bit: synchronous reset, active-high.
REQ-008 SHALL have port i_vert_sync, input, 1 bit: VGA vertical sync, synchronous to i_pix_clk.
REQ-009 SHALL have port i_enable, input, 1 bit: motion enable.
REQ-010 SHALL have port i_load_valid, input, 1 bit, and port o_load_ready, output, 1 bit: sprite state load handshake.
REQ-011 SHALL have port i_load_idx, input, IDX_W bits, and ports i_load_x, i_load_y, i_load_vx, i_load_vy, input, COORD_W bits each, signed: load payload.
REQ-012 SHALL have ports o_x_coords and o_y_coords, output, NUM_SPRITES*COORD_W bits each: packed positions, sprite k at bits [k*COORD_W +: COORD_W].
REQ-013 SHALL have port o_bounce, output, NUM_SPRITES bits: bit k set if sprite k hit an edge in the last pass.
REQ-014 SHALL have port o_busy, output, 1 bit: update pass in progress.
REQ-015 SHALL have port o_frame_done, output, 1 bit: one-cycle pulse when a pass ends.

Function
REQ-016 SHALL register i_vert_sync once and detect a rising edge as i_vert_sync & ~previous value; no clocking on i_vert_sync itself.
REQ-017 SHALL implement a two-state FSM: IDLE, and UPDATE.
REQ-018 SHALL go IDLE->UPDATE on a detected edge with i_enable=1, setting the sprite index to 0 and clearing o_bounce in that same cycle.
REQ-019 SHALL ignore edges that occur in UPDATE or while i_enable=0; no queuing.
REQ-020 SHALL, in UPDATE, process exactly one sprite per cycle in index order, so a pass is NUM_SPRITES cycles and o_busy=1 for exactly those cycles.
REQ-021 SHALL apply the X axis update as follows, with nx = x+vx computed at COORD_W+1 bits:
- nx > XMAX: x=XMAX, vx=-vx, bounce bit set.
- nx < 0: x=0, vx=-vx, bounce bit set.
- otherwise: x=nx.
REQ-022 SHALL apply the same rule to the Y axis against YMAX; one bit o_bounce[k] = X-bounce OR Y-bounce.
REQ-023 SHALL return to IDLE after processing index NUM_SPRITES-1 and pulse o_frame_done high for the first IDLE cycle only.
REQ-024 SHALL update each sprite's outputs in the cycle after that sprite is processed; other sprites hold their values.
REQ-025 SHALL drive o_load_ready = 1 only in IDLE with i_reset=0.
REQ-026 SHALL perform a load on valid&ready, writing x, y, vx, vy of sprite i_load_idx visible next cycle; x clamped to [0,XMAX] and y to [0,YMAX].
REQ-027 SHALL treat a handshake with i_load_idx >= NUM_SPRITES as consumed, with no state change.
REQ-028 SHALL, when a load and a start edge coincide in IDLE, apply the load and start the pass; the pass uses the loaded values.
REQ-029 SHALL leave |v| >= XMAX or |v| >= YMAX and v = -2^(COORD_W-1) as caller error; the result is clamp-correct but velocity sign is undefined.

Reset
REQ-030 SHALL, while i_reset=1, set to 0 all positions, velocities, o_bounce, o_busy, o_frame_done, o_load_ready and the vsync history register; FSM goes to IDLE.
REQ-031 SHALL, on reset asserted mid-pass, abort the pass with no o_frame_done pulse, and be IDLE the cycle after reset deasserts.

Verification
REQ-032 SHALL cover basic motion: reset; load idx0 x=10 y=20 vx=5 vy=6; one vsync rise -> o_busy high 4 cycles, x0=15 y0=26, o_frame_done one 1-cycle pulse, o_bounce=0.
REQ-033 SHALL cover far-edge bounce: load x=780 vx=5, y=582 vy=6 -> x=784 y=584, vx=-5 vy=-6, o_bounce[0]=1; next frame x=779 y=578, o_bounce[0]=0.
REQ-034 SHALL cover near-edge bounce: load x=3 vx=-5, y=2 vy=-6 -> x=0 y=0, vx=5 vy=6; next frame x=5 y=6.
REQ-035 SHALL cover edge detect: vsync held high 10 cycles -> exactly one pass; second rise during o_busy ignored; i_enable=0 with rise -> no change.
REQ-036 SHALL cover load rules: i_load_valid during pass -> ready=0 until IDLE, then accepted; idx=5 -> no change; x=900 -> x=784; y=-7 -> y=0.
REQ-037 SHALL cover reset mid-pass: reset on 2nd UPDATE cycle -> all coords 0, no frame_done, o_load_ready=1 one cycle after deassert.
